// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: serialises
// transactions, steers byte lanes and stalls until ack. Macro MEM_PORT_ARB_RR_EN
// selects round-robin arbitration (default: data has fixed priority).
//
// state   | meaning
// IDLE    | sample requests, pick winner, register address/be/wdata/we
// ISSUE   | mem_req held with stable outputs until mem_gnt
// WAIT    | wait for mem_rvalid, capture read data
// DONE    | one-cycle ack to the winner

`ifndef MEMORY_MODE_WIDTH
`define MEMORY_MODE_WIDTH 2
`endif

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MODE_WIDTH = `MEMORY_MODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [MODE_WIDTH-1:0] d_mode,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_misaligned,
  output logic                  stall,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Mode codes: 0 = byte, 1 = halfword, anything else = word.
  localparam logic [MODE_WIDTH-1:0] MODE_BYTE = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] MODE_HALF = MODE_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  function automatic logic misaligned(input logic [MODE_WIDTH-1:0] m, input logic [1:0] lo);
    if (m == MODE_BYTE)      return 1'b0;
    else if (m == MODE_HALF) return lo[0];
    else                     return |lo;
  endfunction

  function automatic logic [3:0] be_of(input logic [MODE_WIDTH-1:0] m, input logic [1:0] lo);
    if (m == MODE_BYTE)      return 4'b0001 << lo;
    else if (m == MODE_HALF) return lo[1] ? 4'b1100 : 4'b0011;
    else                     return 4'b1111;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wdata_of(input logic [MODE_WIDTH-1:0] m,
                                                    input logic [DATA_WIDTH-1:0] w);
    if (m == MODE_BYTE)      return {(DATA_WIDTH/8){w[7:0]}};
    else if (m == MODE_HALF) return {(DATA_WIDTH/16){w[15:0]}};
    else                     return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rdata_of(input logic [MODE_WIDTH-1:0] m,
                                                    input logic [1:0] lo,
                                                    input logic [DATA_WIDTH-1:0] r);
    logic [DATA_WIDTH-1:0] s;
    s = r >> {lo, 3'b000};
    if (m == MODE_BYTE)      return {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
    else if (m == MODE_HALF) return {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
    else                     return s;
  endfunction

  state_t                state_q, state_d;
  logic                  win_data_q, win_data_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic [1:0]            lo_q, lo_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  d_pend, d_mis, pick_data;

  assign d_pend = d_read | d_write;
  assign d_mis  = misaligned(d_mode, d_addr[1:0]);

`ifdef MEM_PORT_ARB_RR_EN
  logic last_data_q, last_data_d;
  // Data wins a tie only if fetch was the last one served.
  assign pick_data = d_pend & (~if_req | ~last_data_q);
`else
  assign pick_data = d_pend;
`endif

  always_comb begin
    state_d     = state_q;
    win_data_d  = win_data_q;
    mode_d      = mode_q;
    lo_d        = lo_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    mis_d       = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
    last_data_d = last_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req | d_pend) begin
          win_data_d = pick_data;
`ifdef MEM_PORT_ARB_RR_EN
          last_data_d = pick_data;
`endif
          if (pick_data) begin
            mode_d = d_mode;
            lo_d   = d_addr[1:0];
            if (d_mis) begin
              mis_d     = 1'b1;
              d_ack_d   = 1'b1;
              d_rdata_d = '0;
              mem_we_d  = 1'b0;
              state_d   = S_DONE;
            end else begin
              mem_we_d    = d_write;
              mem_addr_d  = d_addr & WORD_MASK;
              mem_be_d    = be_of(d_mode, d_addr[1:0]);
              mem_wdata_d = wdata_of(d_mode, d_wdata);
              state_d     = S_ISSUE;
            end
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr & WORD_MASK;
            mem_be_d   = 4'b1111;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: if (mem_gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          mem_we_d = 1'b0;
          state_d  = S_DONE;
          if (win_data_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = rdata_of(mode_q, lo_q, mem_rdata);
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mem_req_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      win_data_q  <= 1'b0;
      mode_q      <= '0;
      lo_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      mis_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_data_q  <= win_data_d;
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      mis_q       <= mis_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef MEM_PORT_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_data_q <= 1'b0;
    else        last_data_q <= last_data_d;
  end
`endif

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign if_ack       = if_ack_q;
  assign d_ack        = d_ack_q;
  assign d_misaligned = mis_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign stall        = (if_req & ~if_ack) | (d_pend & ~d_ack);

endmodule
